spi_burst_loader: RTL and testbench

Parametrised SPI/QSPI master that streams 32-bit words from an AXI-Stream-style read buffer into the SPI slave memory port of the PULP system, then releases fetch_enable.
- Successor to the fixed two-address loader: arbitrary base address, automatic chip-select re-framing every BURST_WORDS words with address re-issue, valid/ready backpressure, and a programmable SCK divider.
- Sits between the read buffer and the SoC SPI slave pins.

---
 rtl/spi_burst_loader.sv | 217 +++++++++++++++++++++
 tb/tb_spi_burst_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_loader.sv
// SPI/QSPI master streaming words from a valid/ready buffer into the SoC SPI slave, re-framing every BURST_WORDS.
// Optional build macro SPI_LOADER_CFG_EN adds a single-line QPI-enable configuration frame ahead of quad loads.
module spi_burst_loader #(
    parameter int         DATA_W      = 32,
    parameter int         BURST_WORDS = 128,
    parameter int         SCK_DIV     = 1,
    parameter int         CS_GAP      = 2,
    parameter logic [7:0] CMD_WRITE   = 8'h02,
    parameter logic [7:0] CMD_CFG     = 8'h01,
    parameter logic [7:0] CFG_VAL     = 8'h01
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       base_addr,
    input  logic [31:0]       num_words,
    input  logic              use_qspi,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic              spi_sck,
    output logic              spi_csn,
    output logic [3:0]        spi_sdo,
    output logic [3:0]        spi_oe,
    output logic              busy,
    output logic              done,
    output logic              fetch_enable,
    output logic [31:0]       words_sent
);
    localparam int SR_W = (DATA_W > 32) ? DATA_W : 32;
    localparam int CMAX = (SR_W > CS_GAP) ? SR_W : CS_GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int DW   = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int FW   = $clog2(BURST_WORDS + 1);

`ifdef SPI_LOADER_CFG_EN
    localparam bit CFG_EN = 1'b1;
`else
    localparam bit CFG_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        ST_IDLE, ST_CFG, ST_CGAP, ST_CMD, ST_ADDR, ST_WAIT, ST_DATA, ST_GAP, ST_FIN, ST_DONE
    } state_t;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] num;
        logic        quad;
    } load_cfg_t;

    state_t          state_q, state_d;
    load_cfg_t       cfg_q, cfg_d;
    logic [DW-1:0]   div_q, div_d;
    logic            sck_q, sck_d;
    logic [SR_W-1:0] sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     ws_q, ws_d;
    logic [FW-1:0]   frm_q, frm_d;
    logic            last_q, last_d;

    logic        half_tick, lanes4, shifting, timed, shift_end, csn_low;
    logic [31:0] frame_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            div_q   <= '0;
            sck_q   <= 1'b0;
            sr_q    <= '0;
            cnt_q   <= '0;
            ws_q    <= '0;
            frm_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            div_q   <= div_d;
            sck_q   <= sck_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            ws_q    <= ws_d;
            frm_q   <= frm_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        div_d   = div_q;
        sck_d   = sck_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        ws_d    = ws_q;
        frm_d   = frm_q;
        last_d  = last_q;

        half_tick  = (div_q == DW'(SCK_DIV - 1));
        lanes4     = cfg_q.quad && (state_q != ST_CFG);
        shifting   = (state_q == ST_CFG) || (state_q == ST_CMD) ||
                     (state_q == ST_ADDR) || (state_q == ST_DATA);
        timed      = shifting || (state_q == ST_CGAP) || (state_q == ST_GAP) || (state_q == ST_FIN);
        shift_end  = shifting && half_tick && sck_q && (cnt_q == CW'(1));
        frame_addr = cfg_q.base + {ws_q[29:0], 2'b00};

        if (timed)
            div_d = half_tick ? '0 : div_q + DW'(1);

        // Rising edge mid-bit; data advances only on the falling edge so sdo never moves while sck is high.
        if (shifting && half_tick) begin
            if (!sck_q) begin
                sck_d = 1'b1;
            end else begin
                sck_d = 1'b0;
                sr_d  = lanes4 ? (sr_q << 4) : (sr_q << 1);
                cnt_d = cnt_q - CW'(1);
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cfg_d  = '{base: base_addr, num: num_words, quad: use_qspi};
                    ws_d   = '0;
                    frm_d  = '0;
                    last_d = 1'b0;
                    div_d  = '0;
                    sck_d  = 1'b0;
                    if (CFG_EN && use_qspi) begin
                        state_d = ST_CFG;
                        sr_d    = SR_W'({CMD_CFG, CFG_VAL}) << (SR_W - 16);
                        cnt_d   = CW'(16);
                    end else begin
                        state_d = ST_CMD;
                        sr_d    = SR_W'(CMD_WRITE) << (SR_W - 8);
                        cnt_d   = use_qspi ? CW'(2) : CW'(8);
                    end
                end
            end
            ST_CFG: begin
                if (shift_end) begin
                    state_d = ST_CGAP;
                    cnt_d   = CW'(CS_GAP);
                end
            end
            ST_CGAP, ST_GAP: begin
                if (half_tick) begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_CMD;
                        sr_d    = SR_W'(CMD_WRITE) << (SR_W - 8);
                        cnt_d   = cfg_q.quad ? CW'(2) : CW'(8);
                    end
                end
            end
            ST_CMD: begin
                if (shift_end) begin
                    state_d = ST_ADDR;
                    sr_d    = SR_W'(frame_addr) << (SR_W - 32);
                    cnt_d   = cfg_q.quad ? CW'(8) : CW'(32);
                end
            end
            ST_ADDR: begin
                if (shift_end)
                    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (s_tvalid) begin
                    state_d = ST_DATA;
                    sr_d    = SR_W'(s_tdata) << (SR_W - DATA_W);
                    last_d  = s_tlast;
                    cnt_d   = cfg_q.quad ? CW'(DATA_W / 4) : CW'(DATA_W);
                    div_d   = '0;
                end
            end
            ST_DATA: begin
                if (shift_end) begin
                    ws_d  = ws_q + 32'd1;
                    frm_d = frm_q + FW'(1);
                    if (((cfg_q.num != 32'd0) && (ws_q + 32'd1 == cfg_q.num)) || last_q) begin
                        state_d = ST_FIN;
                        cnt_d   = CW'(1);
                    end else if (frm_q == FW'(BURST_WORDS - 1)) begin
                        state_d = ST_GAP;
                        cnt_d   = CW'(CS_GAP);
                        frm_d   = '0;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_FIN: begin
                if (half_tick)
                    state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign csn_low = (state_q == ST_CFG) || (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                     (state_q == ST_WAIT) || (state_q == ST_DATA);

    assign spi_csn      = ~csn_low;
    assign spi_sck      = sck_q;
    assign spi_oe       = !csn_low ? 4'b0000 : (lanes4 ? 4'b1111 : 4'b0001);
    assign spi_sdo      = !shifting ? 4'b0000 :
                          (lanes4 ? sr_q[SR_W-1 -: 4] : {3'b000, sr_q[SR_W-1]});
    assign s_tready     = (state_q == ST_WAIT) && s_tvalid;
    assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done         = (state_q == ST_DONE);
    assign fetch_enable = (state_q == ST_DONE);
    assign words_sent   = ws_q;

endmodule

// File: tb/tb_spi_burst_loader.sv
// Directed bench for spi_burst_loader: decodes the SPI pins back into frames and bits and checks them
// against hand-computed streams (single, quad with re-framing, stall, tlast, mid-frame reset).
module tb_spi_burst_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr, num_words;
    logic        use_qspi;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tlast, s_tready;
    logic        spi_sck, spi_csn;
    logic [3:0]  spi_sdo, spi_oe;
    logic        busy, done, fetch_enable;
    logic [31:0] words_sent;

`ifdef SPI_LOADER_CFG_EN
    localparam int CO = 16, CF = 1;
`else
    localparam int CO = 0, CF = 0;
`endif

    always #5 clk = ~clk;

    spi_burst_loader #(.BURST_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_words(num_words),
        .use_qspi(use_qspi), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready), .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_sdo(spi_sdo),
        .spi_oe(spi_oe), .busy(busy), .done(done), .fetch_enable(fetch_enable),
        .words_sent(words_sent)
    );

    int n_cmp = 0, n_err = 0;
    logic [31:0] words [0:15];

    // Pin decoder, sampled mid-cycle
    logic clr;
    logic rx [0:1023];
    int   nbits, nfrm, hi_run, low_run, max_low, sck_bad, n_hs, n_rdy;
    int   frm_sck [0:15];
    int   gap_cyc [0:15];
    logic csn_p, sck_p;

    always @(negedge clk) begin
        if (clr) begin
            nbits <= 0; nfrm <= 0; hi_run <= 0; low_run <= 0; max_low <= 0;
            sck_bad <= 0; n_hs <= 0; n_rdy <= 0; csn_p <= 1'b1; sck_p <= 1'b0;
        end else begin
            if (!spi_csn && csn_p && nfrm < 16) begin
                if (nfrm > 0) gap_cyc[nfrm] <= hi_run;
                frm_sck[nfrm] <= 0;
                nfrm <= nfrm + 1;
            end
            hi_run <= spi_csn ? hi_run + 1 : 0;
            if (spi_sck && !sck_p && !spi_csn && nfrm > 0 && nbits < 1020) begin
                frm_sck[nfrm-1] <= frm_sck[nfrm-1] + 1;
                if (spi_oe == 4'b1111) begin
                    rx[nbits]   <= spi_sdo[3];
                    rx[nbits+1] <= spi_sdo[2];
                    rx[nbits+2] <= spi_sdo[1];
                    rx[nbits+3] <= spi_sdo[0];
                    nbits <= nbits + 4;
                end else begin
                    rx[nbits] <= spi_sdo[0];
                    nbits <= nbits + 1;
                end
            end
            if (spi_sck && spi_csn) sck_bad <= sck_bad + 1;
            if (!spi_csn && !spi_sck) begin
                low_run <= low_run + 1;
                if (low_run + 1 > max_low) max_low <= low_run + 1;
            end else begin
                low_run <= 0;
            end
            if (s_tvalid && s_tready) n_hs <= n_hs + 1;
            if (s_tready) n_rdy <= n_rdy + 1;
            csn_p <= spi_csn;
            sck_p <= spi_sck;
        end
    end

    function automatic logic [31:0] field(input int pos, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = {v[30:0], rx[pos+i]};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_load(input logic [31:0] base, input logic [31:0] nw, input logic q,
                            input int avail, input int tl, input int st_after, input int st_len,
                            input bit poke);
        int  idx, stall;
        bit  hs;
        idx = 0; stall = 0;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        base_addr = base; num_words = nw; use_qspi = q; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_cleared", done, 0);
        for (int cyc = 0; cyc < 20000; cyc++) begin
            s_tdata  = words[idx];
            s_tvalid = (idx < avail) && (stall == 0);
            s_tlast  = (idx == tl);
            if (poke && cyc == 60) begin
                start = 1'b1; base_addr = 32'hFFFF0000; num_words = 32'd1; use_qspi = ~q;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            hs = s_tvalid && s_tready;
            @(posedge clk); #1;
            if (hs) begin
                idx++;
                if (idx == st_after) stall = st_len;
            end else if (stall > 0) begin
                stall--;
            end
            if (done) break;
        end
        start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
        chk("load_completes", done, 1);
        chk("no_sck_while_csn_high", sck_bad, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; use_qspi = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; clr = 1'b1;
        for (int i = 0; i < 16; i++) words[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_csn", spi_csn, 1);
        chk("rst_sck", spi_sck, 0);
        chk("rst_sdo", spi_sdo, 0);
        chk("rst_oe", spi_oe, 0);
        chk("rst_tready", s_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fetch", fetch_enable, 0);
        chk("rst_words", words_sent, 0);
        rst_n = 1'b1;

        // Single mode, three always-valid words in one frame
        words[0] = 32'hDEADBEEF; words[1] = 32'h12345678; words[2] = 32'h00000000;
        run_load(32'h0, 32'd3, 1'b0, 3, -1, -1, 0, 1'b0);
        chk("t1_frames", nfrm, 1);
        chk("t1_sck", frm_sck[0], 136);
        chk("t1_bits", nbits, 136);
        chk("t1_cmd", field(0, 8), 32'h02);
        chk("t1_addr", field(8, 32), 32'h0);
        chk("t1_w0", field(40, 32), 32'hDEADBEEF);
        chk("t1_w1", field(72, 32), 32'h12345678);
        chk("t1_w2", field(104, 32), 32'h0);
        chk("t1_fetch", fetch_enable, 1);
        chk("t1_busy", busy, 0);
        chk("t1_words", words_sent, 3);
        chk("t1_hs", n_hs, 3);

        // Quad, two frames of 4+2, stray start while busy, tlast on a word that is never reached
        words[0] = 32'h01234567; words[1] = 32'h89ABCDEF; words[2] = 32'hFEDCBA98;
        words[3] = 32'h76543210; words[4] = 32'hC0FFEE00; words[5] = 32'h0BADF00D;
        words[6] = 32'h11111111; words[7] = 32'h22222222;
        run_load(32'h00100000, 32'd6, 1'b1, 8, 6, -1, 0, 1'b1);
`ifdef SPI_LOADER_CFG_EN
        chk("t2_cfg_sck", frm_sck[0], 16);
        chk("t2_cfg_bits", field(0, 16), 32'h0101);
        chk("t2_cfg_gap", gap_cyc[1], 2);
`endif
        chk("t2_frames", nfrm, 2 + CF);
        chk("t2_f1_sck", frm_sck[CF], 42);
        chk("t2_f2_sck", frm_sck[CF+1], 26);
        chk("t2_gap", gap_cyc[CF+1], 2);
        chk("t2_cmd1", field(CO, 8), 32'h02);
        chk("t2_addr1", field(CO + 8, 32), 32'h00100000);
        chk("t2_w0", field(CO + 40, 32), 32'h01234567);
        chk("t2_w3", field(CO + 136, 32), 32'h76543210);
        chk("t2_cmd2", field(CO + 168, 8), 32'h02);
        chk("t2_addr2", field(CO + 176, 32), 32'h00100010);
        chk("t2_w4", field(CO + 208, 32), 32'hC0FFEE00);
        chk("t2_w5", field(CO + 240, 32), 32'h0BADF00D);
        chk("t2_bits", nbits, CO + 272);
        chk("t2_words", words_sent, 6);
        chk("t2_hs", n_hs, 6);

        // Stall after the first word: bus pauses low inside the frame, stream unchanged
        words[0] = 32'hDEADBEEF; words[1] = 32'h12345678; words[2] = 32'h00000000;
        run_load(32'h0, 32'd3, 1'b0, 3, -1, 1, 90, 1'b0);
        chk("t3_frames", nfrm, 1);
        chk("t3_sck", frm_sck[0], 136);
        chk("t3_stall_seen", max_low >= 20, 1);
        chk("t3_w0", field(40, 32), 32'hDEADBEEF);
        chk("t3_w1", field(72, 32), 32'h12345678);
        chk("t3_w2", field(104, 32), 32'h0);

        // num_words=0, tlast on the fifth word, base near top of address space
        for (int i = 0; i < 8; i++) words[i] = 32'hA0000000 + i;
        run_load(32'hFFFFFFF8, 32'd0, 1'b0, 8, 4, -1, 0, 1'b0);
        chk("t4_words", words_sent, 5);
        chk("t4_hs", n_hs, 5);
        chk("t4_rdy_cycles", n_rdy, 5);
        chk("t4_frames", nfrm, 2);
        chk("t4_f2_sck", frm_sck[1], 72);
        chk("t4_addr1", field(8, 32), 32'hFFFFFFF8);
        chk("t4_addr2", field(176, 32), 32'h00000008);
        chk("t4_w4", field(208, 32), 32'hA0000004);

        // Reset in the middle of the address phase, then a clean load
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        base_addr = 32'h40; num_words = 32'd3; use_qspi = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("t5_in_frame", spi_csn, 0);
        rst_n = 1'b0;
        #1;
        chk("t5_csn", spi_csn, 1);
        chk("t5_sck", spi_sck, 0);
        chk("t5_oe", spi_oe, 0);
        chk("t5_busy", busy, 0);
        chk("t5_words", words_sent, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        words[0] = 32'hDEADBEEF; words[1] = 32'h12345678; words[2] = 32'h00000000;
        run_load(32'h0, 32'd3, 1'b0, 3, -1, -1, 0, 1'b0);
        chk("t5_frames", nfrm, 1);
        chk("t5_sck_total", frm_sck[0], 136);
        chk("t5_w0", field(40, 32), 32'hDEADBEEF);
        chk("t5_done_words", words_sent, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
